// File: rtl/ram64x8_arb_pkg.sv
// Shared constants and types for the two-port ram64x8 arbiter.
package ram64x8_arb_pkg;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // Which requester a grant or pointer refers to.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/ram64x8_arb_rr_arb2.sv
// Combinational two-way round-robin pick. The "last granted" pointer is
// held by the parent; on a tie the port that did not win last time wins.
module rr_arb2
    import ram64x8_arb_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_e last,
    output port_e sel,
    output logic  valid
);

    // Single requester wins outright; a tie goes to the port not granted last.
    always_comb begin
        valid = req_a | req_b;
        if (req_a && req_b) begin
            sel = (last == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            sel = PORT_B;
        end else begin
            sel = PORT_A;
        end
    end

endmodule

// File: rtl/ram64x8_arb.sv
// Owner of a single ram64x8 array shared by two requesters. After reset it
// optionally fills every word with INIT_VAL, then serves one single-word
// access at a time (grant cycle, then an idle/return cycle) with
// round-robin fairness between ports A and B.
module ram64x8_arb
    import ram64x8_arb_pkg::*;
#(
    parameter bit          INIT_EN  = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          init_done
);

    state_e        state_q, state_d;
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    port_e         last_q, last_d;
    port_e         op_port_q, op_port_d;
    logic          op_read_q, op_read_d;

    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          ram_wen_q, ram_wen_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          init_done_q, init_done_d;

    port_e         arb_sel;
    logic          arb_valid;

    rr_arb2 u_rr_arb2 (
        .req_a (req_a),
        .req_b (req_b),
        .last  (last_q),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Next-state and next-output decode; outputs are registered, so the
    // values chosen here appear on the pins in the following cycle.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        last_d      = last_q;
        op_port_d   = op_port_q;
        op_read_d   = op_read_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        rvalid_a_d  = 1'b0;
        rvalid_b_d  = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;

        case (state_q)
            ST_INIT: begin
                // Leave once the write of the top word is on the RAM pins.
                if (ram_wen_q && ram_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_wen_d  = 1'b1;
                    ram_addr_d = fill_cnt_q;
                    ram_din_d  = INIT_VAL;
                    // Saturate at the top address instead of wrapping.
                    if (fill_cnt_q != LAST_ADDR) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d   = ST_ACCESS;
                    last_d    = arb_sel;
                    op_port_d = arb_sel;
                    if (arb_sel == PORT_A) begin
                        gnt_a_d    = 1'b1;
                        ram_wen_d  = we_a;
                        ram_addr_d = addr_a;
                        ram_din_d  = wdata_a;
                        op_read_d  = ~we_a;
                    end else begin
                        gnt_b_d    = 1'b1;
                        ram_wen_d  = we_b;
                        ram_addr_d = addr_b;
                        ram_din_d  = wdata_b;
                        op_read_d  = ~we_b;
                    end
                end
            end
            ST_ACCESS: begin
                // Requests are ignored here so a requester that has not yet
                // dropped req after its grant cannot be served twice.
                state_d = ST_IDLE;
                if (op_read_q) begin
                    if (op_port_q == PORT_A) begin
                        rvalid_a_d = 1'b1;
                        rdata_a_d  = ram_dout;
                    end else begin
                        rvalid_b_d = 1'b1;
                        rdata_b_d  = ram_dout;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        init_done_d = (state_d != ST_INIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
            fill_cnt_q  <= '0;
            last_q      <= PORT_B;
            op_port_q   <= PORT_A;
            op_read_q   <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            last_q      <= last_d;
            op_port_q   <= op_port_d;
            op_read_q   <= op_read_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            rvalid_a_q  <= rvalid_a_d;
            rvalid_b_q  <= rvalid_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            init_done_q <= init_done_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign init_done = init_done_q;
    // A reset arriving during a write's grant cycle must keep that write
    // out of the array, so the enable is masked by rst directly.
    assign ram_wen   = ram_wen_q & ~rst;

endmodule

// File: tb/tb_ram64x8_arb.sv
// Directed bench for ram64x8_arb: one instance with the fill enabled and one
// with it disabled, each wired to a behavioural ram64x8 model.
module tb_ram64x8_arb;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance 0: INIT_EN=1, INIT_VAL=00 ----------------
    logic       rst = 1'b1;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [5:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wen, init_done;
    logic [7:0] rdata_a, rdata_b, ram_din, ram_dout;
    logic [5:0] ram_addr;
    logic [7:0] mem0 [64];

    ram64x8_arb #(.INIT_EN(1'b1), .INIT_VAL(8'h00)) dut0 (
        .ck(ck), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .init_done(init_done)
    );

    always @(posedge ck) if (ram_wen) mem0[ram_addr] <= ram_din;
    assign ram_dout = mem0[ram_addr];

    // ---------------- instance 1: INIT_EN=0 ----------------
    logic       rst1 = 1'b1;
    logic       req_a1 = 1'b0, we_a1 = 1'b0, req_b1 = 1'b0, we_b1 = 1'b0;
    logic [5:0] addr_a1 = '0, addr_b1 = '0;
    logic [7:0] wdata_a1 = '0, wdata_b1 = '0;
    logic       gnt_a1, gnt_b1, rvalid_a1, rvalid_b1, ram_wen1, init_done1;
    logic [7:0] rdata_a1, rdata_b1, ram_din1, ram_dout1;
    logic [5:0] ram_addr1;
    logic [7:0] mem1 [64];

    ram64x8_arb #(.INIT_EN(1'b0), .INIT_VAL(8'h00)) dut1 (
        .ck(ck), .rst(rst1),
        .req_a(req_a1), .we_a(we_a1), .addr_a(addr_a1), .wdata_a(wdata_a1),
        .gnt_a(gnt_a1), .rvalid_a(rvalid_a1), .rdata_a(rdata_a1),
        .req_b(req_b1), .we_b(we_b1), .addr_b(addr_b1), .wdata_b(wdata_b1),
        .gnt_b(gnt_b1), .rvalid_b(rvalid_b1), .rdata_b(rdata_b1),
        .ram_wen(ram_wen1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_dout(ram_dout1), .init_done(init_done1)
    );

    always @(posedge ck) if (ram_wen1) mem1[ram_addr1] <= ram_din1;
    assign ram_dout1 = mem1[ram_addr1];

    // One line per granted access or returned read.
    always @(negedge ck) begin
        if (gnt_a)    $display("%0t dut0 grant A we=%0b addr=%h din=%h", $time, ram_wen, ram_addr, ram_din);
        if (gnt_b)    $display("%0t dut0 grant B we=%0b addr=%h din=%h", $time, ram_wen, ram_addr, ram_din);
        if (rvalid_a) $display("%0t dut0 rdata A %h", $time, rdata_a);
        if (rvalid_b) $display("%0t dut0 rdata B %h", $time, rdata_b);
        if (gnt_a1)   $display("%0t dut1 grant A we=%0b addr=%h din=%h", $time, ram_wen1, ram_addr1, ram_din1);
        if (rvalid_a1) $display("%0t dut1 rdata A %h", $time, rdata_a1);
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    logic [35:0] obs;

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        obs = {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, ram_wen, ram_addr, ram_din, init_done};
        n_cmp++;
        if (obs !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 000000000", obs);
        end
    endtask

    // Fill with req_a held from cycle 3; A's read is granted only in cycle 66.
    task automatic test_init();
        int gnt_seen = 0;
        rst = 1'b0;                       // this is cycle 0
        n_cmp++;
        if ({ram_wen, init_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL init_cycle0: got wen/done=%b expected 00", {ram_wen, init_done});
        end
        for (int c = 1; c <= 64; c++) begin
            step();
            if (c == 3) begin
                req_a = 1'b1; we_a = 1'b0; addr_a = 6'h11;
            end
            if (gnt_a) gnt_seen++;
            n_cmp++;
            if ({ram_wen, ram_addr, ram_din, init_done} !== {1'b1, 6'(c - 1), 8'h00, 1'b0}) begin
                n_bad++;
                $display("FAIL init_fill c=%0d: got wen=%b addr=%h din=%h done=%b expected 1 %h 00 0",
                         c, ram_wen, ram_addr, ram_din, init_done, 6'(c - 1));
            end
        end
        step();                           // cycle 65
        if (gnt_a) gnt_seen++;
        n_cmp++;
        if ({init_done, ram_wen} !== 2'b10) begin
            n_bad++;
            $display("FAIL init_done65: got done/wen=%b expected 10", {init_done, ram_wen});
        end
        n_cmp++;
        if (gnt_seen !== 0) begin
            n_bad++;
            $display("FAIL init_no_gnt: got %0d grants during fill expected 0", gnt_seen);
        end
        step();                           // cycle 66
        n_cmp++;
        if ({gnt_a, gnt_b, ram_wen, ram_addr} !== {3'b100, 6'h11}) begin
            n_bad++;
            $display("FAIL init_first_gnt: got gnt_a/gnt_b/wen/addr=%b expected 100010001", {gnt_a, gnt_b, ram_wen, ram_addr});
        end
        req_a = 1'b0;
        step();                           // cycle 67
        n_cmp++;
        if ({rvalid_a, rvalid_b, rdata_a} !== {2'b10, 8'h00}) begin
            n_bad++;
            $display("FAIL init_first_read: got rvalid_a/b=%b rdata_a=%h expected 10 00", {rvalid_a, rvalid_b}, rdata_a);
        end
    endtask

    task automatic test_write_read_a();
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'h05; wdata_a = 8'h2A;
        step();
        n_cmp++;
        if ({gnt_a, ram_wen, ram_addr, ram_din} !== {2'b11, 6'h05, 8'h2A}) begin
            n_bad++;
            $display("FAIL wr_a_grant: got gnt/wen=%b addr=%h din=%h expected 11 05 2a", {gnt_a, ram_wen}, ram_addr, ram_din);
        end
        we_a = 1'b0;                      // next request: read back the same word
        step();
        n_cmp++;
        if ({gnt_a, rvalid_a} !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_a_gap: got gnt/rvalid=%b expected 00", {gnt_a, rvalid_a});
        end
        step();
        n_cmp++;
        if ({gnt_a, ram_wen, ram_addr} !== {2'b10, 6'h05}) begin
            n_bad++;
            $display("FAIL rd_a_grant: got gnt/wen=%b addr=%h expected 10 05", {gnt_a, ram_wen}, ram_addr);
        end
        req_a = 1'b0;
        step();
        n_cmp++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'h2A}) begin
            n_bad++;
            $display("FAIL rd_a_data: got rvalid=%b rdata=%h expected 1 2a", rvalid_a, rdata_a);
        end
        step();
        n_cmp++;
        if ({rvalid_a, rdata_a} !== {1'b0, 8'h2A}) begin
            n_bad++;
            $display("FAIL rd_a_hold: got rvalid=%b rdata=%h expected 0 2a", rvalid_a, rdata_a);
        end
    endtask

    // B writes FF to 30, A reads it back, B reads 3F (leaves pointer at B).
    task automatic test_port_b();
        req_b = 1'b1; we_b = 1'b1; addr_b = 6'h30; wdata_b = 8'hFF;
        step();
        n_cmp++;
        if ({gnt_a, gnt_b, ram_wen, ram_addr, ram_din} !== {3'b011, 6'h30, 8'hFF}) begin
            n_bad++;
            $display("FAIL wr_b_grant: got gnt_a/gnt_b/wen=%b addr=%h din=%h expected 011 30 ff",
                     {gnt_a, gnt_b, ram_wen}, ram_addr, ram_din);
        end
        req_b = 1'b0;
        step();
        n_cmp++;
        if (rvalid_b !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_b_no_rvalid: got %b expected 0", rvalid_b);
        end
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'h30;
        step();
        req_a = 1'b0;
        step();
        n_cmp++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'hFF}) begin
            n_bad++;
            $display("FAIL rd_a_30: got rvalid=%b rdata=%h expected 1 ff", rvalid_a, rdata_a);
        end
        req_b = 1'b1; we_b = 1'b0; addr_b = 6'h3F;
        step();
        n_cmp++;
        if ({gnt_b, ram_addr} !== {1'b1, 6'h3F}) begin
            n_bad++;
            $display("FAIL rd_b_grant: got gnt_b=%b addr=%h expected 1 3f", gnt_b, ram_addr);
        end
        req_b = 1'b0;
        step();
        n_cmp++;
        if ({rvalid_b, rdata_b} !== {1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL rd_b_3f: got rvalid=%b rdata=%h expected 1 00", rvalid_b, rdata_b);
        end
    endtask

    // Both ports held: grants alternate A,B,A,B two cycles apart.
    task automatic test_round_robin();
        logic [7:0] exp_rd [4];
        logic [5:0] next_addr [4];
        logic       exp_a;
        exp_rd    = '{8'h2A, 8'h00, 8'hFF, 8'h00};
        next_addr = '{6'h30, 6'h06, 6'h01, 6'h00};
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'h05;
        req_b = 1'b1; we_b = 1'b0; addr_b = 6'h3F;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            step();
            n_cmp++;
            if ({gnt_a, gnt_b} !== {exp_a, ~exp_a}) begin
                n_bad++;
                $display("FAIL rr_grant i=%0d: got gnt_a/gnt_b=%b expected %b", i, {gnt_a, gnt_b}, {exp_a, ~exp_a});
            end
            if (exp_a) addr_a = next_addr[i];
            else       addr_b = next_addr[i];
            if (i == 3) begin
                req_a = 1'b0; req_b = 1'b0;
            end
            step();
            n_cmp++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b, (exp_a ? rdata_a : rdata_b)} !== {2'b00, exp_a, ~exp_a, exp_rd[i]}) begin
                n_bad++;
                $display("FAIL rr_return i=%0d: got gnt=%b rvalid=%b rdata=%h expected 00 %b %h",
                         i, {gnt_a, gnt_b}, {rvalid_a, rvalid_b}, (exp_a ? rdata_a : rdata_b), {exp_a, ~exp_a}, exp_rd[i]);
            end
        end
    endtask

    // Reset lands in B's write grant cycle: write dropped, fill restarts.
    task automatic test_reset_mid();
        req_b = 1'b1; we_b = 1'b1; addr_b = 6'h10; wdata_b = 8'h77;
        step();
        n_cmp++;
        if ({gnt_b, ram_addr} !== {1'b1, 6'h10}) begin
            n_bad++;
            $display("FAIL rm_grant: got gnt_b=%b addr=%h expected 1 10", gnt_b, ram_addr);
        end
        rst = 1'b1; req_b = 1'b0;
        #1;
        n_cmp++;
        if (ram_wen !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_wen_masked: got %b expected 0", ram_wen);
        end
        step();
        n_cmp++;
        if (mem0[16] !== 8'h00) begin
            n_bad++;
            $display("FAIL rm_no_write: got mem[10]=%h expected 00", mem0[16]);
        end
        obs = {gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, ram_wen, ram_addr, ram_din, init_done};
        n_cmp++;
        if (obs !== 36'h0) begin
            n_bad++;
            $display("FAIL rm_outputs_zero: got %h expected 000000000", obs);
        end
        rst = 1'b0;                       // cycle 0
        for (int c = 1; c <= 64; c++) begin
            step();
            n_cmp++;
            if ({ram_wen, ram_addr, init_done} !== {1'b1, 6'(c - 1), 1'b0}) begin
                n_bad++;
                $display("FAIL rm_refill c=%0d: got wen=%b addr=%h done=%b expected 1 %h 0",
                         c, ram_wen, ram_addr, init_done, 6'(c - 1));
            end
        end
        step();                           // cycle 65
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10;
        req_b = 1'b1; we_b = 1'b0; addr_b = 6'h11;
        step();
        n_cmp++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            n_bad++;
            $display("FAIL rm_first_tie: got gnt_a/gnt_b=%b expected 10", {gnt_a, gnt_b});
        end
        req_a = 1'b0;
        step();
        n_cmp++;
        if ({rvalid_a, rdata_a} !== {1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL rm_read_10: got rvalid=%b rdata=%h expected 1 00", rvalid_a, rdata_a);
        end
        step();
        n_cmp++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            n_bad++;
            $display("FAIL rm_b_after: got gnt_a/gnt_b=%b expected 01", {gnt_a, gnt_b});
        end
        req_b = 1'b0;
        step();
    endtask

    // INIT_EN=0: done in cycle 1, no fill writes, normal access after.
    task automatic test_init_en0();
        int wen_seen = 0;
        rst1 = 1'b1;
        step();
        n_cmp++;
        if ({init_done1, ram_wen1} !== 2'b00) begin
            n_bad++;
            $display("FAIL ie0_reset: got done/wen=%b expected 00", {init_done1, ram_wen1});
        end
        rst1 = 1'b0;                      // cycle 0
        step();                           // cycle 1
        n_cmp++;
        if ({init_done1, ram_wen1} !== 2'b10) begin
            n_bad++;
            $display("FAIL ie0_done_c1: got done/wen=%b expected 10", {init_done1, ram_wen1});
        end
        for (int c = 2; c <= 4; c++) begin
            step();
            if (ram_wen1) wen_seen++;
        end
        n_cmp++;
        if (wen_seen !== 0) begin
            n_bad++;
            $display("FAIL ie0_no_fill: got %0d write cycles expected 0", wen_seen);
        end
        req_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 6'h07; wdata_a1 = 8'h33;
        step();
        n_cmp++;
        if ({gnt_a1, ram_wen1, ram_addr1, ram_din1} !== {2'b11, 6'h07, 8'h33}) begin
            n_bad++;
            $display("FAIL ie0_wr_grant: got gnt/wen=%b addr=%h din=%h expected 11 07 33",
                     {gnt_a1, ram_wen1}, ram_addr1, ram_din1);
        end
        we_a1 = 1'b0;
        step();
        step();
        n_cmp++;
        if ({gnt_a1, ram_wen1} !== 2'b10) begin
            n_bad++;
            $display("FAIL ie0_rd_grant: got gnt/wen=%b expected 10", {gnt_a1, ram_wen1});
        end
        req_a1 = 1'b0;
        step();
        n_cmp++;
        if ({rvalid_a1, rdata_a1} !== {1'b1, 8'h33}) begin
            n_bad++;
            $display("FAIL ie0_rd_data: got rvalid=%b rdata=%h expected 1 33", rvalid_a1, rdata_a1);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read_a();
        test_port_b();
        test_round_robin();
        test_reset_mid();
        test_init_en0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Grants to both ports at once are never legal.
    always @(negedge ck) begin
        if (gnt_a && gnt_b) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dual_grant: got gnt_a=1 gnt_b=1 expected at most one");
        end
    end

endmodule
